dht_sensor_ctrl: RTL and testbench

Parametrised single-wire controller for DHT11 and DHT22 humidity/temperature sensors, selectable per transaction. It replaces the fixed-period DHT11 reader as the sensor front end of the Basys3 SoC AXI peripheral. Each read is started on request and enforces the sensor's minimum re-read interval. Results are returned as signed fixed-point ×10 values, with timeout and checksum errors reported.

---
 rtl/dht_pkg.sv | 30 +++
 rtl/dht_sensor_ctrl_tick.sv | 29 ++
 rtl/dht_sensor_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dht_sensor_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// dht_pkg: FSM states, error/mode codes and the x10 shift-add helper shared by the
// dht_sensor_ctrl slice.
package dht_pkg;

    typedef enum logic [3:0] {
        ST_HOLDOFF,
        ST_IDLE,
        ST_START_LOW,
        ST_RELEASE,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_NORESP = 2'd1;
    localparam logic [1:0] ERR_BITTO  = 2'd2;
    localparam logic [1:0] ERR_CSUM   = 2'd3;

    localparam logic MODE_DHT11 = 1'b0;
    localparam logic MODE_DHT22 = 1'b1;

    // v*10 as (v<<3) + (v<<1)
    function automatic logic [15:0] times10(input logic [7:0] v);
        return {5'd0, v, 3'd0} + {7'd0, v, 1'd0};
    endfunction

endpackage

// File: rtl/dht_sensor_ctrl_tick.sv
// onewire_us_tick: one-cycle pulse every CLK_HZ/1e6 clocks, the microsecond time base
// for the single-wire sensor controller.
module onewire_us_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset_p,
    output logic us_tick
);
    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt     <= '0;
            us_tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            us_tick <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            us_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht_sensor_ctrl.sv
// dht_sensor_ctrl: on-demand DHT11/DHT22 reader with re-read holdoff, timeouts and checksum.
// Define DHT_ERRCNT_EN to add the saturating error counter (clr_cnt / err_cnt).
module dht_sensor_ctrl
    import dht_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int START_LOW11_US  = 20000,
    parameter int START_LOW22_US  = 1100,
    parameter int RESP_TIMEOUT_US = 100,
    parameter int BIT_TIMEOUT_US  = 120,
    parameter int BIT_THRESH_US   = 50,
    parameter int HOLDOFF_US      = 2_000_000
) (
    input  logic               clk,
    input  logic               reset_p,
    input  logic               start,
    input  logic               mode,
    inout  wire                dht_io,
    output logic               busy,
    output logic               valid,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [15:0]        hum_x10,
    output logic signed [15:0] temp_x10
`ifdef DHT_ERRCNT_EN
    ,
    input  logic               clr_cnt,
    output logic [7:0]         err_cnt
`endif
);
    localparam logic [21:0] START11_T = 22'(START_LOW11_US);
    localparam logic [21:0] START22_T = 22'(START_LOW22_US);
    localparam logic [21:0] RESP_TO_T = 22'(RESP_TIMEOUT_US);
    localparam logic [21:0] BIT_TO_T  = 22'(BIT_TIMEOUT_US);
    localparam logic [21:0] THRESH_T  = 22'(BIT_THRESH_US);
    localparam logic [21:0] HOLDOFF_T = 22'(HOLDOFF_US);

    state_t      state, state_next;
    logic        us_tick;
    logic [21:0] us_cnt;
    logic        sync_p0, sync_p1, sync_p2;
    logic        rise, fall, edge_seen;
    logic        mode_r, pending;
    logic [5:0]  bit_cnt;
    logic [39:0] shreg;
    logic        drive_low, resp_to, bit_to;
    logic [21:0] start_low_t;
    logic [7:0]  b0, b1, b2, b3, b4, csum;

    function automatic logic [15:0] conv_hum(input logic m, input logic [7:0] hi, input logic [7:0] lo);
        return (m == MODE_DHT22) ? {hi, lo} : times10(hi) + {8'd0, lo};
    endfunction

    function automatic logic signed [15:0] conv_temp(input logic m, input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] mag;
        logic        neg;
        if (m == MODE_DHT22) begin
            mag = {1'b0, hi[6:0], lo};
            neg = hi[7];
        end else begin
            mag = times10(hi) + {12'd0, lo[3:0]};
            neg = lo[7];
        end
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    onewire_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .us_tick (us_tick)
    );

    assign dht_io = drive_low ? 1'b0 : 1'bz;

    // Input stage: p0/p1 synchronise, p2 holds the previous level for edge detection
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
        end else begin
            sync_p0 <= dht_io;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise        = sync_p1 & ~sync_p2;
    assign fall        = ~sync_p1 & sync_p2;
    assign start_low_t = (mode_r == MODE_DHT22) ? START22_T : START11_T;
    assign {b0, b1, b2, b3, b4} = shreg;
    assign csum        = b0 + b1 + b2 + b3;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) state <= ST_HOLDOFF;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_HOLDOFF:   if (us_cnt >= HOLDOFF_T) state_next = (pending || start) ? ST_START_LOW : ST_IDLE;
            ST_IDLE:      if (start) state_next = ST_START_LOW;
            ST_START_LOW: if (us_cnt >= start_low_t) state_next = ST_RELEASE;
            ST_RELEASE:   if (edge_seen) state_next = ST_RESP_LOW;
            ST_RESP_LOW:  if (edge_seen) state_next = ST_RESP_HIGH;
            ST_RESP_HIGH: if (edge_seen) state_next = ST_BIT_LOW;
            ST_BIT_LOW:   if (edge_seen) state_next = ST_BIT_HIGH;
            ST_BIT_HIGH:  if (edge_seen) state_next = (bit_cnt == 6'd39) ? ST_CHECK : ST_BIT_LOW;
            ST_CHECK:     state_next = ST_HOLDOFF;
            default:      state_next = ST_HOLDOFF;
        endcase
        if (resp_to || bit_to) state_next = ST_HOLDOFF;
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        drive_low = (state == ST_START_LOW);
        edge_seen = 1'b0;
        case (state)
            ST_RELEASE, ST_RESP_HIGH, ST_BIT_HIGH: edge_seen = fall;
            ST_RESP_LOW, ST_BIT_LOW:               edge_seen = rise;
            default:                               edge_seen = 1'b0;
        endcase
        resp_to = (state inside {ST_RELEASE, ST_RESP_LOW, ST_RESP_HIGH}) && !edge_seen && (us_cnt >= RESP_TO_T);
        bit_to  = (state inside {ST_BIT_LOW, ST_BIT_HIGH}) && !edge_seen && (us_cnt >= BIT_TO_T);
    end

    // Datapath: phase timer, bit shifter, result registers and status pulses
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            us_cnt   <= '0;
            mode_r   <= MODE_DHT11;
            pending  <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            valid    <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            hum_x10  <= '0;
            temp_x10 <= '0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (state_next != state || edge_seen) us_cnt <= '0;
            else if (us_tick)                     us_cnt <= us_cnt + 22'd1;
            if (start && (state == ST_IDLE || state == ST_HOLDOFF)) mode_r <= mode;
            if (state_next == ST_START_LOW && state != ST_START_LOW) pending <= 1'b0;
            else if (state == ST_HOLDOFF && start)                   pending <= 1'b1;
            if (state == ST_RESP_HIGH && edge_seen) bit_cnt <= '0;
            if (state == ST_BIT_HIGH && edge_seen) begin
                shreg   <= {shreg[38:0], (us_cnt >= THRESH_T)};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (resp_to) begin
                error    <= 1'b1;
                err_code <= ERR_NORESP;
            end else if (bit_to) begin
                error    <= 1'b1;
                err_code <= ERR_BITTO;
            end else if (state == ST_CHECK) begin
                if (csum == b4) begin
                    valid    <= 1'b1;
                    err_code <= ERR_NONE;
                    hum_x10  <= conv_hum(mode_r, b0, b1);
                    temp_x10 <= conv_temp(mode_r, b2, b3);
                end else begin
                    error    <= 1'b1;
                    err_code <= ERR_CSUM;
                end
            end
        end
    end

`ifdef DHT_ERRCNT_EN
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)                       err_cnt <= '0;
        else if (clr_cnt)                  err_cnt <= '0;
        else if (error && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// Bench for dht_sensor_ctrl: behavioural sensor on the open-drain line, table of reads
// checked against an arithmetic reference model, plus holdoff/timeout/reset sequences.
`timescale 1ns/1ps
module tb_dht_sensor_ctrl;

    localparam int CLK_HZ = 10_000_000;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        sens_low = 1'b0;
    wire         dht_line;
    logic        busy, valid, error;
    logic [1:0]  err_code;
    logic [15:0] hum_x10, temp_x10;
`ifdef DHT_ERRCNT_EN
    logic        clr_cnt = 1'b0;
    logic [7:0]  err_cnt;
`endif

    assign dht_line = sens_low ? 1'b0 : 1'bz;
    pullup (dht_line);

    always #50 clk = ~clk;

    dht_sensor_ctrl #(
        .CLK_HZ         (CLK_HZ),
        .START_LOW11_US (100),
        .START_LOW22_US (60),
        .BIT_THRESH_US  (10),
        .HOLDOFF_US     (50)
    ) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .start    (start),
        .mode     (mode),
        .dht_io   (dht_line),
        .busy     (busy),
        .valid    (valid),
        .error    (error),
        .err_code (err_code),
        .hum_x10  (hum_x10),
        .temp_x10 (temp_x10)
`ifdef DHT_ERRCNT_EN
        ,
        .clr_cnt  (clr_cnt),
        .err_cnt  (err_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Pulse and line monitors
    int  n_valid = 0, n_error = 0, n_both = 0, n_low = 0;
    time t_pulse = 0;
    always @(negedge clk) begin
        if (valid) n_valid++;
        if (error) n_error++;
        if (valid && error) n_both++;
        if (valid || error) t_pulse = $time;
        if (dht_line !== 1'b1) n_low++;
    end

    // Reference model: the conversion rules in plain integer arithmetic
    logic [15:0] ref_hum, ref_temp;
    function automatic void ref_model(input logic m, input logic [39:0] d, output logic ok, output logic [1:0] code);
        int b[5];
        int h, t;
        for (int i = 0; i < 5; i++) b[i] = int'(d[39-8*i -: 8]);
        ok = ((b[0] + b[1] + b[2] + b[3]) % 256) == b[4];
        if (!ok) begin
            code = 2'd3;
            return;
        end
        code = 2'd0;
        if (m == 1'b0) begin
            h = b[0] * 10 + b[1];
            t = b[2] * 10 + (b[3] % 16);
            if (b[3] >= 128) t = -t;
        end else begin
            h = b[0] * 256 + b[1];
            t = (b[2] % 128) * 256 + b[3];
            if (b[2] >= 128) t = -t;
        end
        ref_hum  = h[15:0];
        ref_temp = t[15:0];
    endfunction

    task automatic pulse_start(input logic m);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_line(input logic lvl, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (dht_line === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_busy_low(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pulse(input int nv, input int ne, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (n_valid != nv || n_error != ne) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Sensor: response 10/10 us, bits 5 us low then 3 us (0) or 16 us (1) high
    task automatic sensor_read(input logic [39:0] d, input int inject_bit, input int abort_bit, output bit ok);
        wait_line(1'b0, 2000, ok);
        if (!ok) return;
        wait_line(1'b1, 2000, ok);
        if (!ok) return;
        #10000 sens_low = 1'b1;
        #10000 sens_low = 1'b0;
        #10000;
        for (int i = 0; i < 40; i++) begin
            sens_low = 1'b1;
            if (i == inject_bit) pulse_start(1'b1);
            #5000 sens_low = 1'b0;
            if (i == abort_bit) begin
                #5000;
                return;
            end
            if (d[39-i]) #16000;
            else         #3000;
        end
        sens_low = 1'b1;
        #5000 sens_low = 1'b0;
    endtask

    typedef struct packed {
        logic        mode;
        logic [39:0] data;
        logic        exp_ok;
        logic [1:0]  exp_err;
        logic [15:0] exp_hum;
        logic [15:0] exp_temp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #8ms;
        $display("FAIL watchdog: simulation exceeded 8 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok, m_ok;
        logic [1:0]  m_code;
        logic [39:0] d;
        logic        m;
        int          nv, ne, l0;
        time         tv, ts, t0;

        vecs[0] = '{mode: 1'b0, data: 40'h37_00_19_05_55, exp_ok: 1'b1, exp_err: 2'd0, exp_hum: 16'd550, exp_temp: 16'd255};
        vecs[1] = '{mode: 1'b1, data: 40'h02_8C_80_65_73, exp_ok: 1'b1, exp_err: 2'd0, exp_hum: 16'd652, exp_temp: 16'hFF9B};
        vecs[2] = '{mode: 1'b0, data: 40'h37_00_19_05_56, exp_ok: 1'b0, exp_err: 2'd3, exp_hum: 16'd652, exp_temp: 16'hFF9B};
        ref_hum  = 16'd652;
        ref_temp = 16'hFF9B;
        for (int i = 3; i < 5; i++) begin
            m = 1'($urandom_range(0, 1));
            d = {$urandom, 8'($urandom)};
            if ($urandom_range(0, 3) != 0) d[7:0] = d[39:32] + d[31:24] + d[23:16] + d[15:8];
            ref_model(m, d, m_ok, m_code);
            vecs[i] = '{mode: m, data: d, exp_ok: m_ok, exp_err: m_code, exp_hum: ref_hum, exp_temp: ref_temp};
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1);
        check("reset_valid", valid, 0);
        check("reset_error", error, 0);
        check("reset_err_code", err_code, 0);
        check("reset_hum", hum_x10, 0);
        check("reset_temp", temp_x10, 0);
        check("reset_line_released", dht_line === 1'b1, 1);
        @(posedge clk); #1 reset_p = 1'b0;
        #20000;
        check("holdoff_after_reset_busy", busy, 1);
        wait_busy_low(1000, ok);
        check("holdoff_to_idle", ok, 1);

        for (int i = 0; i < 5; i++) begin
            wait_busy_low(2000, ok);
            check("idle_before_read", ok, 1);
            nv = n_valid;
            ne = n_error;
            pulse_start(vecs[i].mode);
            sensor_read(vecs[i].data, (i == 1) ? 10 : -1, -1, ok);
            check("sensor_handshake", ok, 1);
            wait_pulse(nv, ne, 200, ok);
            check("pulse_seen", ok, 1);
            repeat (2) @(negedge clk);
            check("valid_pulses", n_valid - nv, 32'(vecs[i].exp_ok));
            check("error_pulses", n_error - ne, 32'(!vecs[i].exp_ok));
            check("err_code", err_code, vecs[i].exp_err);
            check("hum_x10", hum_x10, vecs[i].exp_hum);
            check("temp_x10", temp_x10, vecs[i].exp_temp);
`ifdef DHT_ERRCNT_EN
            if (i == 2) begin
                check("err_cnt_after_csum", err_cnt, 1);
                @(posedge clk); #1 clr_cnt = 1'b1;
                @(posedge clk); #1 clr_cnt = 1'b0;
                check("err_cnt_cleared", err_cnt, 0);
            end
`endif
            if (i == 1) begin
                l0 = n_low;
                #80000;
                check("ignored_start_no_start_low", n_low - l0, 0);
                check("ignored_start_reaches_idle", busy, 0);
            end
        end

        // start during HOLDOFF is deferred until the holdoff expires; then the sensor stays silent
        tv = t_pulse;
        pulse_start(1'b0);
        wait_line(1'b0, 700, ok);
        check("pending_start_low_seen", ok, 1);
        check_rng("pending_start_delay_ns", $time - tv, 48800, 50300);
        ts = $time;
        wait_line(1'b1, 1500, ok);
        check("start_low11_released", ok, 1);
        check_rng("start_low11_width_ns", $time - ts, 98900, 100400);
        t0 = $time;
        l0 = n_low;
        nv = n_valid;
        ne = n_error;
        wait_pulse(nv, ne, 1300, ok);
        check("noresp_pulse_seen", ok, 1);
        @(negedge clk);
        check("noresp_error_pulses", n_error - ne, 1);
        check("noresp_no_valid", n_valid - nv, 0);
        check("noresp_err_code", err_code, 1);
        check_rng("noresp_delay_ns", t_pulse - t0, 98000, 102000);
        check("noresp_line_never_low", n_low - l0, 0);
        check("noresp_back_to_holdoff", busy, 1);

        // Reset while bit 20 is being received
        wait_busy_low(2000, ok);
        check("idle_before_abort", ok, 1);
        nv = n_valid;
        ne = n_error;
        pulse_start(1'b1);
        sensor_read(40'h01_02_03_04_0A, -1, 20, ok);
        check("abort_handshake", ok, 1);
        #20 reset_p = 1'b1;
        #1;
        check("abort_line_released", dht_line === 1'b1, 1);
        check("abort_busy", busy, 1);
        check("abort_hum_cleared", hum_x10, 0);
        check("abort_temp_cleared", temp_x10, 0);
        check("abort_valid_low", valid, 0);
        check("abort_error_low", error, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset_p = 1'b0;
        #30000;
        check("abort_no_valid", n_valid - nv, 0);
        check("abort_no_error", n_error - ne, 0);

        // Reset while the controller holds the line low releases it without a clock edge
        wait_busy_low(2000, ok);
        check("idle_before_startlow_reset", ok, 1);
        pulse_start(1'b1);
        wait_line(1'b0, 100, ok);
        check("startlow_seen", ok, 1);
        #10020 reset_p = 1'b1;
        #1;
        check("startlow_async_release", dht_line === 1'b1, 1);
        check("startlow_reset_busy", busy, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset_p = 1'b0;

        check("never_valid_and_error", n_both, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
